// File: rtl/norm_seq_ctrl_if.sv
// Bus between norm_seq_ctrl (master) and the normalisation unit (slave):
// write/divide/clear strobes out, full/ready/quotient back.
interface norm_seq_ctrl_if #(
  parameter int bw = 4
);
  logic [bw-1:0]   norm_in;
  logic            norm_wr;
  logic            norm_div;
  logic            norm_reset;
  logic            norm_o_full;
  logic            norm_o_ready;
  logic [2*bw-1:0] norm_out;

  modport master (
    output norm_in, norm_wr, norm_div, norm_reset,
    input  norm_o_full, norm_o_ready, norm_out
  );

  modport slave (
    input  norm_in, norm_wr, norm_div, norm_reset,
    output norm_o_full, norm_o_ready, norm_out
  );
endinterface

// File: rtl/norm_seq_ctrl.sv
// Sequencer for the normalisation unit: clear, stream a vector in, then one divide per element.
// Optional watchdog abort is built when NORM_SEQ_CTRL_WATCHDOG_EN is defined.
module norm_seq_ctrl #(
  parameter int bw     = 4,
  parameter int cnt_w  = 4,
  parameter int TO_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [cnt_w-1:0] len,
  input  logic             in_valid,
  input  logic [bw-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2*bw-1:0]  out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  norm_seq_ctrl_if.master  norm
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, LOAD, DIV_ISSUE, DIV_ACK, DIV_WAIT, OUT, DONE
  } state_t;

  state_t           state_reg;
  logic [cnt_w-1:0] len_reg;
  logic [cnt_w-1:0] wr_cnt_reg;
  logic [cnt_w-1:0] rd_cnt_reg;
  logic [cnt_w-1:0] wr_cnt_next;
  logic [cnt_w-1:0] rd_cnt_next;
  logic             out_valid_reg;
  logic [2*bw-1:0]  out_data_reg;
  logic             done_reg;
  logic             norm_div_reg;
  logic             norm_reset_reg;
  logic             wd_expire;

  assign wr_cnt_next = wr_cnt_reg + 1'b1;
  assign rd_cnt_next = rd_cnt_reg + 1'b1;

  // Loading is the only combinational path: the element goes straight through to the unit.
  assign in_ready      = (state_reg == LOAD) && !norm.norm_o_full;
  assign norm.norm_wr  = in_valid && in_ready;
  assign norm.norm_in  = in_data;

  assign norm.norm_div   = norm_div_reg;
  assign norm.norm_reset = norm_reset_reg;
  assign out_valid       = out_valid_reg;
  assign out_data        = out_data_reg;
  assign done            = done_reg;
  assign busy            = (state_reg != IDLE);

`ifdef NORM_SEQ_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TO_CYC + 1);

  logic [WD_W-1:0] wd_cnt_reg;
  logic            wd_watch;
  logic            wd_progress;
  logic            error_reg;

  // Progress is anything that moves the sequence on; it restarts the stall count.
  assign wd_watch    = state_reg inside {LOAD, DIV_ACK, DIV_WAIT};
  assign wd_progress = norm.norm_wr
                    || ((state_reg == DIV_ACK)  && !norm.norm_o_ready)
                    || ((state_reg == DIV_WAIT) &&  norm.norm_o_ready);
  assign wd_expire   = wd_watch && !wd_progress && (wd_cnt_reg == WD_W'(TO_CYC - 1));
  assign error       = error_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_reg <= '0;
      error_reg  <= 1'b0;
    end else begin
      if (!wd_watch || wd_progress || wd_expire)
        wd_cnt_reg <= '0;
      else
        wd_cnt_reg <= wd_cnt_reg + 1'b1;
      if (wd_expire)
        error_reg <= 1'b1;
      else if ((state_reg == IDLE) && start)
        error_reg <= 1'b0;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign error     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      len_reg        <= '0;
      wr_cnt_reg     <= '0;
      rd_cnt_reg     <= '0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      done_reg       <= 1'b0;
      norm_div_reg   <= 1'b0;
      norm_reset_reg <= 1'b0;
    end else begin
      norm_div_reg   <= 1'b0;
      norm_reset_reg <= 1'b0;
      done_reg       <= 1'b0;
      if (wd_expire) begin
        // Abandon the vector and flush whatever the unit holds.
        state_reg      <= IDLE;
        norm_reset_reg <= 1'b1;
        out_valid_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              len_reg        <= len;
              wr_cnt_reg     <= '0;
              rd_cnt_reg     <= '0;
              norm_reset_reg <= 1'b1;
              state_reg      <= CLEAR;
            end
          end
          CLEAR: begin
            if (len_reg != '0) begin
              state_reg <= LOAD;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
          end
          LOAD: begin
            if (norm.norm_wr) begin
              wr_cnt_reg <= wr_cnt_next;
              if (wr_cnt_next == len_reg)
                state_reg <= DIV_ISSUE;
            end
          end
          DIV_ISSUE: begin
            if (norm.norm_o_ready) begin
              norm_div_reg <= 1'b1;
              state_reg    <= DIV_ACK;
            end
          end
          // The unit still shows the old ready while norm_div is high; wait for it to drop.
          DIV_ACK: begin
            if (!norm.norm_o_ready)
              state_reg <= DIV_WAIT;
          end
          DIV_WAIT: begin
            if (norm.norm_o_ready) begin
              out_data_reg  <= norm.norm_out;
              out_valid_reg <= 1'b1;
              state_reg     <= OUT;
            end
          end
          OUT: begin
            if (out_ready) begin
              out_valid_reg <= 1'b0;
              rd_cnt_reg    <= rd_cnt_next;
              if (rd_cnt_next == len_reg) begin
                done_reg  <= 1'b1;
                state_reg <= DONE;
              end else begin
                state_reg <= DIV_ISSUE;
              end
            end
          end
          DONE: state_reg <= IDLE;
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
